// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_ctrl
// Description : Hazard and forwarding controller for the 16-bit five-stage
//               core. Keeps a shadow copy of the register tags held by the
//               EX, MEM and WB stages. From these it drives the EX operand
//               forwarding selects and the stall, bubble and flush controls
//               for load-use, multi-cycle EX and taken-branch hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl #(
  parameter int REG_AW       = 4,
  parameter int MULTI_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IFID_valid,
  input  logic [REG_AW-1:0] IFID_rs1,
  input  logic [REG_AW-1:0] IFID_rs2,
  input  logic              IFID_use_rs1,
  input  logic              IFID_use_rs2,
  input  logic [REG_AW-1:0] IFID_rd,
  input  logic              IFID_regwrite,
  input  logic              IFID_memread,
  input  logic              IFID_multi,
  input  logic              EX_flush,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              PC_write,
  output logic              IFID_write,
  output logic              IFID_flush,
  output logic              IDEX_write,
  output logic              IDEX_bubble,
  output logic              EXMEM_bubble,
  output logic              Multi_busy
);

  // Forwarding mux encodings seen by the EX operand muxes.
  localparam logic [1:0] c_FWD_REGFILE = 2'b00;
  localparam logic [1:0] c_FWD_EXMEM   = 2'b10;
  localparam logic [1:0] c_FWD_MEMWB   = 2'b01;

  // Pipeline control mode, decided fresh every cycle in priority order.
  localparam logic [1:0] c_MODE_RUN   = 2'd0;
  localparam logic [1:0] c_MODE_LOAD  = 2'd1;
  localparam logic [1:0] c_MODE_FLUSH = 2'd2;
  localparam logic [1:0] c_MODE_MULTI = 2'd3;

  // Last stall count value: the op stalls while cnt is below this and
  // advances on the cycle cnt reaches it.
  localparam logic [3:0] c_MULTI_LAST = 4'(MULTI_CYCLES - 1);

  localparam logic [REG_AW-1:0] c_REG_ZERO = '0;

  // --------------------------------------------------------------------------
  // Shadow pipeline state
  // --------------------------------------------------------------------------
  logic              r_ex_valid;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic              r_ex_use1;
  logic              r_ex_use2;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_regwrite;
  logic              r_ex_memread;
  logic              r_ex_multi;

  logic              r_mem_valid;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_regwrite;

  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_regwrite;

  logic [3:0]        r_cnt;

  // Next-state values
  logic              w_ex_valid_nxt;
  logic [REG_AW-1:0] w_ex_rs1_nxt;
  logic [REG_AW-1:0] w_ex_rs2_nxt;
  logic              w_ex_use1_nxt;
  logic              w_ex_use2_nxt;
  logic [REG_AW-1:0] w_ex_rd_nxt;
  logic              w_ex_regwrite_nxt;
  logic              w_ex_memread_nxt;
  logic              w_ex_multi_nxt;

  logic              w_mem_valid_nxt;
  logic [REG_AW-1:0] w_mem_rd_nxt;
  logic              w_mem_regwrite_nxt;

  logic [3:0]        w_cnt_nxt;

  // Hazard detection
  logic              w_mem_hit_rs1;
  logic              w_mem_hit_rs2;
  logic              w_wb_hit_rs1;
  logic              w_wb_hit_rs2;
  logic              w_multi_stall;
  logic              w_load_use;
  logic              w_id_reads_load;
  logic [1:0]        w_mode;

  // A stage produces r when it is a real register-writing instruction whose
  // destination is r; r0 is never produced since it reads as zero.
  function automatic logic f_match(input logic              valid,
                                   input logic              regwrite,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] r);
    f_match = valid & regwrite & (rd != c_REG_ZERO) & (rd == r);
  endfunction

  // Producer matches for the two EX sources.
  always_comb begin
    w_mem_hit_rs1 = f_match(r_mem_valid, r_mem_regwrite, r_mem_rd, r_ex_rs1);
    w_mem_hit_rs2 = f_match(r_mem_valid, r_mem_regwrite, r_mem_rd, r_ex_rs2);
    w_wb_hit_rs1  = f_match(r_wb_valid,  r_wb_regwrite,  r_wb_rd,  r_ex_rs1);
    w_wb_hit_rs2  = f_match(r_wb_valid,  r_wb_regwrite,  r_wb_rd,  r_ex_rs2);
  end

  // Operand forwarding: the younger MEM result wins over the older WB one.
  always_comb begin
    ForwardA = c_FWD_REGFILE;
    ForwardB = c_FWD_REGFILE;
    if (r_ex_use1 && w_mem_hit_rs1) begin
      ForwardA = c_FWD_EXMEM;
    end else if (r_ex_use1 && w_wb_hit_rs1) begin
      ForwardA = c_FWD_MEMWB;
    end
    if (r_ex_use2 && w_mem_hit_rs2) begin
      ForwardB = c_FWD_EXMEM;
    end else if (r_ex_use2 && w_wb_hit_rs2) begin
      ForwardB = c_FWD_MEMWB;
    end
  end

  // Stall conditions: a multi-cycle op still counting, or an instruction in
  // ID that needs the value a load in EX has not fetched yet.
  always_comb begin
    w_multi_stall   = r_ex_valid & r_ex_multi & (r_cnt < c_MULTI_LAST);
    w_id_reads_load = (IFID_use_rs1 & (IFID_rs1 == r_ex_rd)) |
                      (IFID_use_rs2 & (IFID_rs2 == r_ex_rd));
    w_load_use      = r_ex_valid & r_ex_memread & r_ex_regwrite &
                      (r_ex_rd != c_REG_ZERO) & IFID_valid & w_id_reads_load;
  end

  // Mode selection; a branch is never multi-cycle, so a flush request seen
  // during a multi stall belongs to nothing real and is ignored.
  always_comb begin
    w_mode = c_MODE_RUN;
    if (w_multi_stall) begin
      w_mode = c_MODE_MULTI;
    end else if (EX_flush) begin
      w_mode = c_MODE_FLUSH;
    end else if (w_load_use) begin
      w_mode = c_MODE_LOAD;
    end
  end

  // Pipeline register enables and bubble/flush controls for each mode.
  always_comb begin
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_write   = 1'b1;
    IDEX_bubble  = 1'b0;
    EXMEM_bubble = 1'b0;
    Multi_busy   = 1'b0;
    case (w_mode)
      c_MODE_MULTI: begin
        PC_write     = 1'b0;
        IFID_write   = 1'b0;
        IDEX_write   = 1'b0;
        EXMEM_bubble = 1'b1;
        Multi_busy   = 1'b1;
      end
      c_MODE_FLUSH: begin
        IFID_flush  = 1'b1;
        IDEX_bubble = 1'b1;
      end
      c_MODE_LOAD: begin
        PC_write    = 1'b0;
        IFID_write  = 1'b0;
        IDEX_bubble = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Next shadow state mirrors what the real pipeline registers will load.
  always_comb begin
    w_ex_valid_nxt     = IFID_valid;
    w_ex_rs1_nxt       = IFID_rs1;
    w_ex_rs2_nxt       = IFID_rs2;
    w_ex_use1_nxt      = IFID_use_rs1;
    w_ex_use2_nxt      = IFID_use_rs2;
    w_ex_rd_nxt        = IFID_rd;
    w_ex_regwrite_nxt  = IFID_regwrite;
    w_ex_memread_nxt   = IFID_memread;
    w_ex_multi_nxt     = IFID_multi;
    w_mem_valid_nxt    = r_ex_valid;
    w_mem_rd_nxt       = r_ex_rd;
    w_mem_regwrite_nxt = r_ex_regwrite;
    w_cnt_nxt          = 4'd0;
    case (w_mode)
      c_MODE_MULTI: begin
        // EX holds the multi op; a bubble drains into MEM behind it.
        w_ex_valid_nxt     = r_ex_valid;
        w_ex_rs1_nxt       = r_ex_rs1;
        w_ex_rs2_nxt       = r_ex_rs2;
        w_ex_use1_nxt      = r_ex_use1;
        w_ex_use2_nxt      = r_ex_use2;
        w_ex_rd_nxt        = r_ex_rd;
        w_ex_regwrite_nxt  = r_ex_regwrite;
        w_ex_memread_nxt   = r_ex_memread;
        w_ex_multi_nxt     = r_ex_multi;
        w_mem_valid_nxt    = 1'b0;
        w_mem_rd_nxt       = '0;
        w_mem_regwrite_nxt = 1'b0;
        w_cnt_nxt          = r_cnt + 4'd1;
      end
      c_MODE_FLUSH, c_MODE_LOAD: begin
        // The ID instruction does not enter EX; a bubble does instead.
        w_ex_valid_nxt    = 1'b0;
        w_ex_rs1_nxt      = '0;
        w_ex_rs2_nxt      = '0;
        w_ex_use1_nxt     = 1'b0;
        w_ex_use2_nxt     = 1'b0;
        w_ex_rd_nxt       = '0;
        w_ex_regwrite_nxt = 1'b0;
        w_ex_memread_nxt  = 1'b0;
        w_ex_multi_nxt    = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Shadow pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_use1      <= 1'b0;
      r_ex_use2      <= 1'b0;
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_multi     <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
      r_cnt          <= 4'd0;
    end else begin
      r_ex_valid     <= w_ex_valid_nxt;
      r_ex_rs1       <= w_ex_rs1_nxt;
      r_ex_rs2       <= w_ex_rs2_nxt;
      r_ex_use1      <= w_ex_use1_nxt;
      r_ex_use2      <= w_ex_use2_nxt;
      r_ex_rd        <= w_ex_rd_nxt;
      r_ex_regwrite  <= w_ex_regwrite_nxt;
      r_ex_memread   <= w_ex_memread_nxt;
      r_ex_multi     <= w_ex_multi_nxt;
      r_mem_valid    <= w_mem_valid_nxt;
      r_mem_rd       <= w_mem_rd_nxt;
      r_mem_regwrite <= w_mem_regwrite_nxt;
      r_wb_valid     <= r_mem_valid;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      r_cnt          <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_fwd_ctrl
// Description : Directed self-checking bench for hazard_fwd_ctrl. Drives an
//               instruction stream into ID cycle by cycle and compares the
//               forwarding selects and pipeline controls against
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_ctrl;

  localparam int REG_AW       = 4;
  localparam int MULTI_CYCLES = 4;

  logic              clk;
  logic              rst;
  logic              IFID_valid;
  logic [REG_AW-1:0] IFID_rs1;
  logic [REG_AW-1:0] IFID_rs2;
  logic              IFID_use_rs1;
  logic              IFID_use_rs2;
  logic [REG_AW-1:0] IFID_rd;
  logic              IFID_regwrite;
  logic              IFID_memread;
  logic              IFID_multi;
  logic              EX_flush;
  logic [1:0]        ForwardA;
  logic [1:0]        ForwardB;
  logic              PC_write;
  logic              IFID_write;
  logic              IFID_flush;
  logic              IDEX_write;
  logic              IDEX_bubble;
  logic              EXMEM_bubble;
  logic              Multi_busy;

  int n_checks = 0;
  int n_errors = 0;

  hazard_fwd_ctrl #(
    .REG_AW       (REG_AW),
    .MULTI_CYCLES (MULTI_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .IFID_valid    (IFID_valid),
    .IFID_rs1      (IFID_rs1),
    .IFID_rs2      (IFID_rs2),
    .IFID_use_rs1  (IFID_use_rs1),
    .IFID_use_rs2  (IFID_use_rs2),
    .IFID_rd       (IFID_rd),
    .IFID_regwrite (IFID_regwrite),
    .IFID_memread  (IFID_memread),
    .IFID_multi    (IFID_multi),
    .EX_flush      (EX_flush),
    .ForwardA      (ForwardA),
    .ForwardB      (ForwardB),
    .PC_write      (PC_write),
    .IFID_write    (IFID_write),
    .IFID_flush    (IFID_flush),
    .IDEX_write    (IDEX_write),
    .IDEX_bubble   (IDEX_bubble),
    .EXMEM_bubble  (EXMEM_bubble),
    .Multi_busy    (Multi_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk({tag, ".ForwardA"}, ForwardA, a);
    chk({tag, ".ForwardB"}, ForwardB, b);
  endtask

  // Order: PC_write IFID_write IFID_flush IDEX_write IDEX_bubble EXMEM_bubble Multi_busy
  task automatic chk_ctrl(input string tag, input logic [6:0] e);
    chk({tag, ".PC_write"},     {1'b0, PC_write},     {1'b0, e[6]});
    chk({tag, ".IFID_write"},   {1'b0, IFID_write},   {1'b0, e[5]});
    chk({tag, ".IFID_flush"},   {1'b0, IFID_flush},   {1'b0, e[4]});
    chk({tag, ".IDEX_write"},   {1'b0, IDEX_write},   {1'b0, e[3]});
    chk({tag, ".IDEX_bubble"},  {1'b0, IDEX_bubble},  {1'b0, e[2]});
    chk({tag, ".EXMEM_bubble"}, {1'b0, EXMEM_bubble}, {1'b0, e[1]});
    chk({tag, ".Multi_busy"},   {1'b0, Multi_busy},   {1'b0, e[0]});
  endtask

  localparam logic [6:0] CTL_RUN   = 7'b1101000;
  localparam logic [6:0] CTL_LOAD  = 7'b0001100;
  localparam logic [6:0] CTL_FLUSH = 7'b1111100;
  localparam logic [6:0] CTL_MULTI = 7'b0000011;

  task automatic set_id(input logic v, input int rs1, input int rs2,
                        input logic u1, input logic u2, input int rd,
                        input logic rw, input logic mr, input logic mu);
    IFID_valid    = v;
    IFID_rs1      = REG_AW'(rs1);
    IFID_rs2      = REG_AW'(rs2);
    IFID_use_rs1  = u1;
    IFID_use_rs2  = u2;
    IFID_rd       = REG_AW'(rd);
    IFID_regwrite = rw;
    IFID_memread  = mr;
    IFID_multi    = mu;
  endtask

  task automatic nop();
    set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs change 1 time unit after the edge; outputs sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst      = 1'b0;
    EX_flush = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    settle();
    chk_fwd("reset", 2'b00, 2'b00);
    chk_ctrl("reset", CTL_RUN);
    tick();

    // Back-to-back ALU: add r3 ; sub r5,r3,r1
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
    set_id(1, 3, 1, 1, 1, 5, 1, 0, 0); tick();
    nop(); settle();
    chk_fwd("b2b_mem", 2'b10, 2'b00);
    tick();

    // One-instruction gap: add r7 ; nop ; sub r8,r7,r2
    set_id(1, 1, 2, 1, 1, 7, 1, 0, 0); tick();
    nop(); tick();
    set_id(1, 7, 2, 1, 1, 8, 1, 0, 0); tick();
    nop(); settle();
    chk_fwd("gap_wb", 2'b01, 2'b00);
    tick();

    // r0 destination is never forwarded
    set_id(1, 1, 2, 1, 1, 0, 1, 0, 0); tick();
    set_id(1, 0, 0, 1, 1, 9, 1, 0, 0); tick();
    nop(); settle();
    chk_fwd("r0_dest", 2'b00, 2'b00);
    tick();

    // Double hazard on r3: MEM result beats WB result
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
    set_id(1, 1, 3, 1, 1, 10, 1, 0, 0); tick();
    nop(); settle();
    chk_fwd("double", 2'b00, 2'b10);
    tick();

    // Load-use on rs1: lw r4 ; add r6,r4,r2
    set_id(1, 1, 0, 1, 0, 4, 1, 1, 0); settle();
    chk_ctrl("lw_issue", CTL_RUN);
    tick();
    set_id(1, 4, 2, 1, 1, 6, 1, 0, 0); settle();
    chk_ctrl("lu_stall", CTL_LOAD);
    tick();
    settle();
    chk_ctrl("lu_release", CTL_RUN);
    chk_fwd("lu_release", 2'b00, 2'b00);
    tick();
    nop(); settle();
    chk_fwd("lu_fwd", 2'b01, 2'b00);
    tick();

    // Same pair but rs1 not read: no stall and no forwarding on A
    set_id(1, 1, 0, 1, 0, 4, 1, 1, 0); tick();
    set_id(1, 4, 2, 0, 1, 6, 1, 0, 0); settle();
    chk_ctrl("lu_nouse", CTL_RUN);
    tick();
    nop(); settle();
    chk_fwd("lu_nouse", 2'b00, 2'b00);
    tick();

    // Load-use on rs2
    set_id(1, 1, 0, 1, 0, 4, 1, 1, 0); tick();
    set_id(1, 1, 4, 1, 1, 11, 1, 0, 0); settle();
    chk_ctrl("lu_rs2_stall", CTL_LOAD);
    tick();
    settle();
    chk_ctrl("lu_rs2_release", CTL_RUN);
    tick();
    nop(); settle();
    chk_fwd("lu_rs2_fwd", 2'b00, 2'b01);
    tick();

    // Multi-cycle op: mul r12 ; add r13,r12,r1 waits in ID
    set_id(1, 1, 2, 1, 1, 12, 1, 0, 1); tick();
    set_id(1, 12, 1, 1, 1, 13, 1, 0, 0); settle();
    chk_ctrl("mul_c0", CTL_MULTI);
    tick();
    EX_flush = 1'b1; settle();
    chk_ctrl("mul_c1_flushign", CTL_MULTI);
    tick();
    EX_flush = 1'b0; settle();
    chk_ctrl("mul_c2", CTL_MULTI);
    tick();
    settle();
    chk_ctrl("mul_last", CTL_RUN);
    tick();
    nop(); settle();
    chk_fwd("mul_fwd", 2'b10, 2'b00);
    chk_ctrl("mul_after", CTL_RUN);
    tick();

    // Branch flush wins over a simultaneous load-use
    set_id(1, 1, 0, 1, 0, 4, 1, 1, 0); tick();
    set_id(1, 4, 2, 1, 1, 6, 1, 0, 0); EX_flush = 1'b1; settle();
    chk_ctrl("flush", CTL_FLUSH);
    tick();
    EX_flush = 1'b0; nop(); settle();
    chk_ctrl("flush_after", CTL_RUN);
    tick();

    // Reset during a multi stall at cnt=2
    set_id(1, 1, 2, 1, 1, 12, 1, 0, 1); tick();
    nop(); settle();
    chk_ctrl("rmul_c0", CTL_MULTI);
    tick();
    settle();
    chk_ctrl("rmul_c1", CTL_MULTI);
    tick();
    settle();
    chk_ctrl("rmul_c2", CTL_MULTI);
    rst = 1'b0;
    tick();
    rst = 1'b1; settle();
    chk_fwd("rmul_reset", 2'b00, 2'b00);
    chk_ctrl("rmul_reset", CTL_RUN);
    tick();

    // Fresh mul after reset stalls for the full count again
    set_id(1, 1, 2, 1, 1, 12, 1, 0, 1); tick();
    nop();
    for (int i = 0; i < MULTI_CYCLES - 1; i++) begin
      settle();
      chk_ctrl("post_mul_busy", CTL_MULTI);
      tick();
    end
    settle();
    chk_ctrl("post_mul_done", CTL_RUN);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
